timebase_gen: RTL
=================

TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24: phase-accumulator width (8..32).
REQ-003 SHALL have parameter NUM_RST, default 3: number of reset-trigger sources (1..8).
REQ-004 SHALL have parameter RST_LEN, default 16: reset stretch length in tick pulses (2..255).
REQ-005 SHALL have parameter RST_CH, default 0: channel whose ce_out times the stretch.
REQ-006 SHALL have port clk_sys, input, 1: the only clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port inc, input, NUM_CH x ACC_W: per-channel phase increment.
REQ-009 SHALL have port ch_en, input, NUM_CH: per-channel run enable.
REQ-010 SHALL have port ce_out, output, NUM_CH: one-cycle clock-enable pulses.
REQ-011 SHALL have port sq_out, output, NUM_CH: square wave toggling on each ce_out pulse.
REQ-012 SHALL have port rst_src, input, NUM_RST: rising-edge reset triggers; may be asynchronous, so each is double-synchronised.
REQ-013 SHALL have port sys_reset, output, 1: stretched system reset.
REQ-014 SHALL have port rst_busy, output, 1: high while the sequencer is in STRETCH.

Function
REQ-015 Each channel SHALL be a fractional NCO: on every clk_sys edge with ch_en[i]=1, acc_i <= (acc_i+inc_i) mod 2^ACC_W, and ce_out[i] <= carry of that sum.
REQ-016 ce_out[i] SHALL be high for exactly the cycle following an overflowing edge; its long-run rate SHALL be f_clk*inc_i/2^ACC_W.
REQ-017 With ch_en[i]=0, acc_i and sq_out[i] SHALL hold and ce_out[i] SHALL be 0 from the next cycle.
REQ-018 inc_i=0 SHALL produce no pulses; an inc change SHALL take effect on the next edge without clearing acc_i.
REQ-019 sq_out[i] SHALL toggle on the edge after each ce_out[i] pulse, giving half the ce rate.
REQ-020 Edge detection SHALL act on the synchronised rst_src; a trigger is any bit with sync=1 and previous=0. Latency: 3 clk_sys cycles from an input edge to trigger.
REQ-021 The sequencer SHALL have two states, IDLE and STRETCH.
REQ-022 In IDLE with no trigger, the sequencer SHALL stay in IDLE with sys_reset=0.
REQ-023 A trigger in IDLE SHALL enter STRETCH with count=0; sys_reset=1 from the next cycle.
REQ-024 In STRETCH, count SHALL increment on each ce_out[RST_CH] pulse.
REQ-025 At count=RST_LEN-1 with a pulse, the sequencer SHALL return to IDLE; sys_reset=0 from the next cycle.
REQ-026 A trigger during STRETCH SHALL reload count=0 and keep sys_reset high.
REQ-027 A trigger and the terminal pulse in the same cycle SHALL give the trigger priority (restart).
REQ-028 Multiple simultaneous triggers SHALL act as one.
REQ-029 If ch_en[RST_CH]=0 in STRETCH, the sequencer SHALL hold STRETCH indefinitely.
REQ-030 rst_busy SHALL equal (state==STRETCH).

Reset
REQ-031 On reset: acc=0, ce_out=0, sq_out=0, count=0, synchronisers and edge registers=1; a source held high SHALL not trigger on release.
REQ-032 reset SHALL force state=STRETCH and sys_reset=1 (power-on stretch), then RST_LEN ticks after release.
REQ-033 reset asserted mid-stretch SHALL restart from count=0.
REQ-034 No output SHALL be X after one reset cycle.

Structure
REQ-035 Package timebase_pkg SHALL hold the state enum (IDLE, STRETCH) and the parameter-default localparams.
REQ-036 Sub-module timebase_nco (one accumulator, ce, square) SHALL be generated NUM_CH times.
REQ-037 All logic SHALL be in clk_sys; no derived clocks.
REQ-038 An elaboration check SHALL require RST_CH < NUM_CH.

Verification
REQ-039 ACC_W=8, inc0=64, en=1 after reset -> ce_out[0] on cycles 4,8,12,...; sq_out[0] period 8.
REQ-040 ACC_W=8, inc1=96 -> exactly 3 pulses per 8 cycles, pattern repeating (acc 96,192,32c,128,224,64c,160,0c).
REQ-041 ch_en[0] low 5 cycles mid-run -> no pulses, acc held; resumes exact phase.
REQ-042 RST_LEN=4, inc0=64: reset release -> sys_reset high 16 cycles (+1 register latency), rst_busy matches.
REQ-043 rst_src[1] 0->1 in IDLE -> sys_reset rises 4 cycles later; second edge mid-stretch -> count restarts, total length extended.
REQ-044 rst_src[2] held high through reset -> no extra trigger; ch_en[RST_CH]=0 in STRETCH -> sys_reset stays high.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase generator: sequencer states and
// default parameter values.
package timebase_pkg;

    localparam int NUM_CH_DEF  = 3;
    localparam int ACC_W_DEF   = 24;
    localparam int NUM_RST_DEF = 3;
    localparam int RST_LEN_DEF = 16;
    localparam int RST_CH_DEF  = 0;

    // Stretch counter is wide enough for the largest allowed RST_LEN (255).
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } seq_state_t;

endpackage

// File: rtl/timebase_nco.sv
// One fractional NCO channel: phase accumulator whose carry is the
// clock-enable pulse, plus a square wave toggling once per pulse.
module timebase_nco
    import timebase_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce,
    output logic             sq
);

    logic [ACC_W-1:0] acc_reg;
    logic             ce_reg;
    logic             sq_reg;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_reg} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg <= '0;
            ce_reg  <= 1'b0;
            sq_reg  <= 1'b0;
        end else begin
            // The toggle follows the pulse itself, so a pulse produced on the
            // last enabled edge is never lost from the square-wave parity.
            sq_reg <= sq_reg ^ ce_reg;
            if (en) begin
                acc_reg <= sum[ACC_W-1:0];
                ce_reg  <= sum[ACC_W];
            end else begin
                ce_reg  <= 1'b0;
            end
        end
    end

    assign ce = ce_reg;
    assign sq = sq_reg;

endmodule

// File: rtl/timebase_gen.sv
// Multi-channel clock-enable generator with a reset sequencer that stretches
// system reset for RST_LEN ticks of a chosen channel after any trigger.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int NUM_RST = NUM_RST_DEF,
    parameter int RST_LEN = RST_LEN_DEF,
    parameter int RST_CH  = RST_CH_DEF
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [NUM_CH-1:0][ACC_W-1:0] inc,
    input  logic [NUM_CH-1:0]            ch_en,
    output logic [NUM_CH-1:0]            ce_out,
    output logic [NUM_CH-1:0]            sq_out,
    input  logic [NUM_RST-1:0]           rst_src,
    output logic                         sys_reset,
    output logic                         rst_busy
);

    generate
        if (RST_CH < 0 || RST_CH >= NUM_CH) begin : g_bad_rst_ch
            $error("timebase_gen: RST_CH must select an existing channel");
        end
        if (RST_LEN < 2 || RST_LEN > 255) begin : g_bad_rst_len
            $error("timebase_gen: RST_LEN must be within 2..255");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            timebase_nco #(
                .ACC_W (ACC_W)
            ) u_nco (
                .clk  (clk_sys),
                .srst (reset),
                .en   (ch_en[gi]),
                .inc  (inc[gi]),
                .ce   (ce_out[gi]),
                .sq   (sq_out[gi])
            );
        end
    endgenerate

    // Synchronisers and edge history reset high so a source already asserted
    // at reset release is not mistaken for a fresh rising edge.
    logic [NUM_RST-1:0] meta_reg;
    logic [NUM_RST-1:0] sync_reg;
    logic [NUM_RST-1:0] prev_reg;
    logic               trigger;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            meta_reg <= '1;
            sync_reg <= '1;
            prev_reg <= '1;
        end else begin
            meta_reg <= rst_src;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign trigger = |(sync_reg & ~prev_reg);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             sys_reset_reg;
    logic             tick;

    assign tick = ce_out[RST_CH];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    state_next = STRETCH;
                    count_next = '0;
                end
            end
            STRETCH: begin
                // A new trigger always wins, even over the terminal tick.
                if (trigger) begin
                    count_next = '0;
                end else if (tick) begin
                    if (count_reg == CNT_W'(RST_LEN - 1)) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = STRETCH;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= STRETCH;
            count_reg     <= '0;
            sys_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            sys_reset_reg <= (state_reg == STRETCH);
        end
    end

    assign sys_reset = sys_reset_reg;
    assign rst_busy  = (state_reg == STRETCH);

endmodule
